// File: rtl/eta_err_pkg.sv
// Shared types, accumulator widths and saturating-add helper for the error monitor.
package eta_err_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StReport
  } state_e;

  localparam int unsigned SAE_W = 64;
  localparam int unsigned SSE_W = 96;

  // Wide enough that any sum of two operands below 2^SSE_W cannot wrap.
  localparam int unsigned SatW = 128;
  typedef logic [SatW-1:0] sat_t;

  function automatic sat_t sat_add(input sat_t a, input sat_t b, input int unsigned w);
    sat_t sum;
    sat_t lim;
    sum = a + b;
    lim = (sat_t'(1) << w) - sat_t'(1);
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/eta_abs_err.sv
// Stage-1 absolute error |appx - accr|, one bit wider than the operands so it never overflows.
module eta_abs_err #(
  parameter int unsigned DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] appx_i,
  input  logic signed [DATA_W-1:0] accr_i,
  output logic        [DATA_W:0]   ae_o
);

  logic signed [DATA_W:0] diff;

  assign diff = {appx_i[DATA_W-1], appx_i} - {accr_i[DATA_W-1], accr_i};
  assign ae_o = diff[DATA_W] ? -diff : diff;

endmodule

// File: rtl/eta_err_monitor.sv
// Run-based error statistics for approximate adders: count, error count, max/sum abs error.
// Define ETA_ERR_SSE_EN to add the stage-2 squarer and sum-of-squared-errors accumulator.
module eta_err_monitor
  import eta_err_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_appx,
  input  logic signed [DATA_W-1:0] in_accr,
  input  logic                     in_last,
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [CNT_W-1:0]         rpt_count,
  output logic [CNT_W-1:0]         rpt_err_count,
  output logic [DATA_W:0]          rpt_max_ae,
  output logic [SAE_W-1:0]         rpt_sae,
  output logic [SSE_W-1:0]         rpt_sse
);

  state_e state_q, state_d;

  logic              accept;
  logic              flush;
  logic [DATA_W:0]   ae;
  logic              s1_valid_q, s2_valid_q;
  logic [DATA_W:0]   s1_ae_q, s2_ae_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, err_q, err_d;
  logic [DATA_W:0]   max_q, max_d;
  logic [SAE_W-1:0]  sae_q, sae_d;

  assign in_ready  = ~Rst & ((state_q == StIdle) | (state_q == StAccum));
  assign rpt_valid = (state_q == StReport);
  assign accept    = in_valid & in_ready;
  // Report handshake and clear both wipe pipeline and accumulators.
  assign flush     = clear | ((state_q == StReport) & rpt_ready);

  eta_abs_err #(
    .DATA_W(DATA_W)
  ) u_abs (
    .appx_i(in_appx),
    .accr_i(in_accr),
    .ae_o  (ae)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = in_last ? StDrain : StAccum;
      StAccum:  if (accept && in_last) state_d = StDrain;
      StDrain:  if (!s1_valid_q && !s2_valid_q) state_d = StReport;
      StReport: if (rpt_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (clear) state_d = StIdle;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_ae_q    <= '0;
      s2_ae_q    <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept & ~flush;
      s2_valid_q <= s1_valid_q & ~flush;
      s1_ae_q    <= ae;
      s2_ae_q    <= s1_ae_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    max_d = max_q;
    sae_d = sae_q;
    if (flush) begin
      cnt_d = '0;
      err_d = '0;
      max_d = '0;
      sae_d = '0;
    end else if (s2_valid_q) begin
      cnt_d = CNT_W'(sat_add(sat_t'(cnt_q), sat_t'(1), CNT_W));
      if (s2_ae_q != '0) err_d = CNT_W'(sat_add(sat_t'(err_q), sat_t'(1), CNT_W));
      if (s2_ae_q > max_q) max_d = s2_ae_q;
      sae_d = SAE_W'(sat_add(sat_t'(sae_q), sat_t'(s2_ae_q), SAE_W));
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
      err_q <= '0;
      max_q <= '0;
      sae_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      max_q <= max_d;
      sae_q <= sae_d;
    end
  end

  assign rpt_count     = cnt_q;
  assign rpt_err_count = err_q;
  assign rpt_max_ae    = max_q;
  assign rpt_sae       = sae_q;

`ifdef ETA_ERR_SSE_EN
  logic [2*DATA_W+1:0] sq;
  logic [SSE_W-1:0]    sse_q, sse_d;

  assign sq = s2_ae_q * s2_ae_q;

  always_comb begin
    sse_d = sse_q;
    if (flush) begin
      sse_d = '0;
    end else if (s2_valid_q) begin
      sse_d = SSE_W'(sat_add(sat_t'(sse_q), sat_t'(sq), SSE_W));
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) sse_q <= '0;
    else     sse_q <= sse_d;
  end

  assign rpt_sse = sse_q;
`else
  assign rpt_sse = '0;
`endif

endmodule

// File: tb/tb_eta_err_monitor.sv
// Directed and randomized-gap bench for eta_err_monitor with a small reference model.
module tb_eta_err_monitor;

  logic               Clk = 1'b0;
  logic               Rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_appx;
  logic signed [31:0] in_accr;
  logic               in_last;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [31:0]        rpt_count;
  logic [31:0]        rpt_err_count;
  logic [32:0]        rpt_max_ae;
  logic [63:0]        rpt_sae;
  logic [95:0]        rpt_sse;

  int n_checks = 0;
  int n_fail   = 0;

  eta_err_monitor #(
    .DATA_W(32),
    .CNT_W (32)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_appx      (in_appx),
    .in_accr      (in_accr),
    .in_last      (in_last),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_count    (rpt_count),
    .rpt_err_count(rpt_err_count),
    .rpt_max_ae   (rpt_max_ae),
    .rpt_sae      (rpt_sae),
    .rpt_sse      (rpt_sse)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic beat(input logic signed [31:0] a, input logic signed [31:0] b,
                      input logic last);
    in_valid = 1'b1;
    in_appx  = a;
    in_accr  = b;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_rpt(output int n);
    n = 0;
    while (!rpt_valid && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cnt"}, rpt_count, 0);
    check({tag, "_err"}, rpt_err_count, 0);
    check({tag, "_max"}, rpt_max_ae, 0);
    check({tag, "_sae"}, rpt_sae, 0);
    check({tag, "_sse"}, rpt_sse, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0]  snap_cnt, snap_err;
    logic [32:0]  snap_max;
    logic [63:0]  snap_sae;
    logic [95:0]  snap_sse;
    logic         stable, rdy_low;
    longint       a, b, ae;
    int           m_cnt, m_err;
    longint unsigned m_sae, m_sse, m_max;

    Rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_appx = '0; in_accr = '0;
    in_last = 1'b0; rpt_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_rpt_valid", rpt_valid, 0);
    check_zero("rst");
    @(posedge Clk);
    #3 Rst = 1'b0;
    #1 check("rel_in_ready", in_ready, 1);
    step();

    // Basic run: ae = 0, 3, 7
    beat(10, 10, 0);
    beat(5, 8, 0);
    beat(-3, 4, 1);
    check("t1_in_ready_drain", in_ready, 0);
    wait_rpt(n);
    check("t1_latency", n, 3);
    check("t1_cnt", rpt_count, 3);
    check("t1_err", rpt_err_count, 2);
    check("t1_sae", rpt_sae, 10);
    check("t1_max", rpt_max_ae, 7);
`ifdef ETA_ERR_SSE_EN
    check("t1_sse", rpt_sse, 58);
`else
    check("t1_sse", rpt_sse, 0);
`endif
    handshake();
    check("t1_post_valid", rpt_valid, 0);
    check("t1_post_ready", in_ready, 1);
    check_zero("t1_post");

    // Extreme operands, single beat with last straight from idle
    beat(32'sh8000_0000, 32'sh7fff_ffff, 1);
    wait_rpt(n);
    check("t2_latency", n, 3);
    check("t2_cnt", rpt_count, 1);
    check("t2_err", rpt_err_count, 1);
    check("t2_max", rpt_max_ae, 128'd4294967295);
    check("t2_sae", rpt_sae, 128'd4294967295);
`ifdef ETA_ERR_SSE_EN
    check("t2_sse", rpt_sse, 128'd18446744065119617025);
`else
    check("t2_sse", rpt_sse, 0);
`endif
    handshake();

    // Backpressure in REPORT with ignored in_valid pulses
    beat(7, 0, 1);
    wait_rpt(n);
    check("t3_valid", rpt_valid, 1);
    snap_cnt = rpt_count; snap_err = rpt_err_count; snap_max = rpt_max_ae;
    snap_sae = rpt_sae; snap_sse = rpt_sse;
    stable = 1'b1; rdy_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_appx  = 100;
      in_accr  = 0;
      step();
      if (rpt_count != snap_cnt || rpt_err_count != snap_err || rpt_max_ae != snap_max ||
          rpt_sae != snap_sae || rpt_sse != snap_sse || !rpt_valid) stable = 1'b0;
      if (in_ready) rdy_low = 1'b0;
    end
    in_valid = 1'b0;
    check("t3_stable", stable, 1);
    check("t3_ready_low", rdy_low, 1);
    check("t3_cnt", rpt_count, 1);
    check("t3_sae", rpt_sae, 7);
    handshake();
    check("t3_idle_ready", in_ready, 1);
    check_zero("t3_post");

    // Clear on the 4th beat discards it and the partial run
    beat(2, 0, 0);
    beat(2, 0, 0);
    beat(2, 0, 0);
    clear = 1'b1;
    beat(9, 0, 0);
    clear = 1'b0;
    check("t4_ready", in_ready, 1);
    repeat (3) step();
    check("t4_valid", rpt_valid, 0);
    check_zero("t4_flushed");
    beat(1, 0, 1);
    wait_rpt(n);
    check("t4_cnt", rpt_count, 1);
    check("t4_sae", rpt_sae, 1);
    check("t4_max", rpt_max_ae, 1);
    handshake();

    // Asynchronous reset mid-run
    beat(5, 0, 0);
    beat(6, 0, 0);
    repeat (2) step();
    check("t5_pre_cnt", rpt_count, 2);
    check("t5_pre_sae", rpt_sae, 11);
    @(posedge Clk);
    #3 Rst = 1'b1;
    #1;
    check("t5_ready", in_ready, 0);
    check_zero("t5_rst");
    #10 Rst = 1'b0;
    #1 check("t5_rel_ready", in_ready, 1);
    step();
    beat(3, 1, 1);
    wait_rpt(n);
    check("t5_cnt", rpt_count, 1);
    check("t5_sae", rpt_sae, 2);
    handshake();

    // 1000 beats with random gaps against a reference model
    m_cnt = 0; m_err = 0; m_sae = 0; m_sse = 0; m_max = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        in_appx  = $urandom;
        in_accr  = $urandom;
        step();
      end
      a = longint'($urandom_range(0, 4000)) - 2000;
      b = ($urandom_range(0, 3) == 0) ? a : longint'($urandom_range(0, 4000)) - 2000;
      in_valid = 1'b1;
      in_appx  = 32'(a);
      in_accr  = 32'(b);
      in_last  = (i == 999);
      if (in_ready) begin
        ae = (a > b) ? a - b : b - a;
        m_cnt++;
        if (ae != 0) m_err++;
        m_sae += longint'(ae);
        m_sse += longint'(ae * ae);
        if (ae > m_max) m_max = ae;
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_rpt(n);
    check("t6_valid", rpt_valid, 1);
    check("t6_cnt", rpt_count, m_cnt);
    check("t6_err", rpt_err_count, m_err);
    check("t6_sae", rpt_sae, m_sae);
    check("t6_max", rpt_max_ae, m_max);
`ifdef ETA_ERR_SSE_EN
    check("t6_sse", rpt_sse, m_sse);
`else
    check("t6_sse", rpt_sse, 0);
`endif
    handshake();
    check_zero("t6_post");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
